// File: rtl/div_issue_ctrl.sv
// Issue sequencer for the signed/unsigned AXI-stream divider IPs in EXE.
// Latches operands, runs the tvalid handshakes, holds the result until the instruction leaves.
module div_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                es_valid,
    input  logic [1:0]          div_op,
    input  logic [DATA_W-1:0]   src1,
    input  logic [DATA_W-1:0]   src2,
    input  logic                ms_allowin,
    input  logic                flush,
    output logic [3:0]          s_tvalid,
    input  logic [3:0]          s_tready,
    output logic [DATA_W-1:0]   s_dividend,
    output logic [DATA_W-1:0]   s_divisor,
    input  logic [1:0]          m_tvalid,
    input  logic [2*DATA_W-1:0] m_tdata_s,
    input  logic [2*DATA_W-1:0] m_tdata_u,
    output logic                div_ready,
    output logic                hilo_we,
    output logic [DATA_W-1:0]   hi_wdata,
    output logic [DATA_W-1:0]   lo_wdata,
    output logic [CNT_W-1:0]    div_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                sgn_q, sgn_d;
    logic [3:0]          tvalid_q, tvalid_d;
    logic                drop_q, drop_d;
    logic [2*DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;

    logic                div_req;
    logic                dout_v;
    logic [2*DATA_W-1:0] dout;
    logic [CNT_W-1:0]    cnt_inc;

    assign div_req = es_valid & (|div_op);
    assign dout_v  = sgn_q ? m_tvalid[0] : m_tvalid[1];
    assign dout    = sgn_q ? m_tdata_s : m_tdata_u;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sgn_d    = sgn_q;
        tvalid_d = tvalid_q;
        drop_d   = drop_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        hilo_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (div_req && !flush) begin
                    dvd_d    = src1;
                    dvs_d    = src2;
                    sgn_d    = div_op[0];
                    cnt_d    = '0;
                    drop_d   = 1'b0;
                    tvalid_d = div_op[0] ? 4'b0011 : 4'b1100;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                cnt_d    = cnt_inc;
                tvalid_d = tvalid_q & ~s_tready;
                if (flush) drop_d = 1'b1;
                if (tvalid_d == '0) state_d = (drop_q || flush) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A flush coinciding with dout discards it here; DRAIN would wait for a second dout.
                if (dout_v) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        res_d    = dout;
                        cycles_d = cnt_inc;
                        state_d  = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (ms_allowin) begin
                    hilo_we = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (dout_v) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sgn_q    <= 1'b0;
            tvalid_q <= '0;
            drop_q   <= 1'b0;
            res_q    <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sgn_q    <= sgn_d;
            tvalid_q <= tvalid_d;
            drop_q   <= drop_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign div_ready  = !div_req || (state_q == S_DONE);
    assign s_tvalid   = tvalid_q;
    assign s_dividend = dvd_q;
    assign s_divisor  = dvs_q;
    assign hi_wdata   = res_q[DATA_W-1:0];
    assign lo_wdata   = res_q[2*DATA_W-1:DATA_W];
    assign div_cycles = cycles_q;

endmodule
